// File: rtl/mod12_pkg.sv
// Shared constants and state encoding for the mod-12 counter checker.
package mod12_pkg;

   localparam int MODULUS = 12;
   localparam int WIDTH   = 4;

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      LOCKED  = 2'd1,
      ALARM   = 2'd2
   } state_t;

endpackage

// File: rtl/mod12_next_value.sv
// Combinational predictor: next counter value from previous value and direction.
module mod12_next_value
   import mod12_pkg::*;
#(
   parameter int P_MODULUS = MODULUS,
   parameter int P_WIDTH   = WIDTH
) (
   input  logic [P_WIDTH-1:0] prev,
   input  logic               dir,
   output logic [P_WIDTH-1:0] exp_value
);

   localparam logic [P_WIDTH-1:0] TOP = P_WIDTH'(P_MODULUS - 1);

   always_comb begin
      if (dir) exp_value = (prev == TOP) ? '0 : prev + P_WIDTH'(1);
      else     exp_value = (prev == '0) ? TOP : prev - P_WIDTH'(1);
   end

endmodule

// File: rtl/mod12_count_checker.sv
// Receive-side checker for the mod-12 up/down count stream: predicts, locks,
// counts mismatches and raises a sticky alarm after repeated locked errors.
module mod12_count_checker
   import mod12_pkg::*;
#(
   parameter int MODULUS   = mod12_pkg::MODULUS,
   parameter int WIDTH     = mod12_pkg::WIDTH,
   parameter int LOCK_CNT  = 3,
   parameter int ERR_LIMIT = 2,
   parameter int ERRC_W    = 8
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              UpOrDown,
   input  logic              clear_alarm,
   output logic              locked,
   output logic              alarm,
   output logic              err_pulse,
   output logic [ERRC_W-1:0] err_count,
   output logic [WIDTH-1:0]  last_good,
   output logic [1:0]        dbg_state
);

   localparam int STREAK_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W   = $clog2(ERR_LIMIT + 1);

   state_t              state_q, state_d;
   logic                have_prev_q, have_prev_d;
   logic [STREAK_W-1:0] streak_q, streak_d, streak_inc;
   logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic [WIDTH-1:0]    last_good_d;
   logic [ERRC_W-1:0]   err_count_d;
   logic                err;
   logic                illegal;
   logic                match;
   logic [WIDTH-1:0]    exp_value;

   mod12_next_value #(
      .P_MODULUS (MODULUS),
      .P_WIDTH   (WIDTH)
   ) u_next (
      .prev      (prev_q),
      .dir       (UpOrDown),
      .exp_value (exp_value)
   );

   assign illegal    = {1'b0, count_in} >= (WIDTH + 1)'(MODULUS);
   assign match      = have_prev_q && (count_in == exp_value);
   assign streak_inc = streak_q + STREAK_W'(1);
   assign miss_inc   = miss_q + MISS_W'(1);
   assign dbg_state  = state_q;

   always_comb begin
      state_d     = state_q;
      have_prev_d = have_prev_q;
      streak_d    = streak_q;
      miss_d      = miss_q;
      prev_d      = prev_q;
      last_good_d = last_good;
      err         = 1'b0;

      // clear_alarm wins over any same-cycle sample, which is simply dropped
      if (clear_alarm) begin
         state_d     = ACQUIRE;
         have_prev_d = 1'b0;
         streak_d    = '0;
         miss_d      = '0;
      end else if (in_valid && state_q != ALARM) begin
         if (illegal) begin
            err         = 1'b1;
            have_prev_d = 1'b0;
            streak_d    = '0;
            if (state_q == LOCKED) begin
               miss_d = miss_inc;
               if (miss_inc >= MISS_W'(ERR_LIMIT)) state_d = ALARM;
            end
         end else if (!have_prev_q) begin
            prev_d      = count_in;
            have_prev_d = 1'b1;
            streak_d    = '0;
         end else if (state_q == ACQUIRE) begin
            prev_d = count_in;
            if (match) begin
               last_good_d = count_in;
               streak_d    = streak_inc;
               if (streak_inc >= STREAK_W'(LOCK_CNT)) begin
                  state_d = LOCKED;
                  miss_d  = '0;
               end
            end else begin
               streak_d = '0;
            end
         end else begin
            // LOCKED: mismatches resync prev so one glitch costs one error
            prev_d = count_in;
            if (match) begin
               last_good_d = count_in;
               miss_d      = '0;
            end else begin
               err    = 1'b1;
               miss_d = miss_inc;
               if (miss_inc >= MISS_W'(ERR_LIMIT)) state_d = ALARM;
            end
         end
      end

      if (clear_alarm)                 err_count_d = '0;
      else if (err && err_count != '1) err_count_d = err_count + ERRC_W'(1);
      else                             err_count_d = err_count;
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q     <= ACQUIRE;
         have_prev_q <= 1'b0;
         streak_q    <= '0;
         miss_q      <= '0;
         prev_q      <= '0;
         last_good   <= '0;
         err_count   <= '0;
         err_pulse   <= 1'b0;
         locked      <= 1'b0;
         alarm       <= 1'b0;
      end else begin
         state_q     <= state_d;
         have_prev_q <= have_prev_d;
         streak_q    <= streak_d;
         miss_q      <= miss_d;
         prev_q      <= prev_d;
         last_good   <= last_good_d;
         err_count   <= err_count_d;
         err_pulse   <= err;
         locked      <= (state_d == LOCKED);
         alarm       <= (state_d == ALARM);
      end
   end

endmodule

// File: tb/tb_mod12_count_checker.sv
// Directed bench for mod12_count_checker: one task per scenario, inline checks.
module tb_mod12_count_checker;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] count_in = '0;
   logic       UpOrDown = 1'b1;
   logic       clear_alarm = 1'b0;
   logic       locked, alarm, err_pulse;
   logic [7:0] err_count;
   logic [3:0] last_good;
   logic [1:0] dbg_state;

   int errors = 0;
   int checks = 0;

   mod12_count_checker dut (
      .Clk         (Clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .count_in    (count_in),
      .UpOrDown    (UpOrDown),
      .clear_alarm (clear_alarm),
      .locked      (locked),
      .alarm       (alarm),
      .err_pulse   (err_pulse),
      .err_count   (err_count),
      .last_good   (last_good),
      .dbg_state   (dbg_state)
   );

   always #5 Clk = ~Clk;

   // drive one sample; returns #1 after the sampling edge so outputs can be checked
   task automatic send(input logic [3:0] v, input logic d);
      @(negedge Clk);
      in_valid = 1'b1;
      count_in = v;
      UpOrDown = d;
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
      checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%0b exp=0", alarm); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%0b exp=0", err_pulse); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcount got=%0d exp=0", err_count); end
      checks++; if (last_good !== 4'd0) begin errors++; $display("FAIL reset_lastgood got=%0d exp=0", last_good); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
   endtask

   task automatic test_lock_up();
      do_reset();
      send(4'd0, 1'b1); send(4'd1, 1'b1); send(4'd2, 1'b1);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got=%0b exp=0", locked); end
      send(4'd3, 1'b1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_up got=%0b exp=1", locked); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL lock_errcount got=%0d exp=0", err_count); end
      checks++; if (last_good !== 4'd3) begin errors++; $display("FAIL lock_lastgood got=%0d exp=3", last_good); end
      // idle cycles hold everything
      repeat (3) @(posedge Clk);
      #1;
      checks++; if (locked !== 1'b1 || err_pulse !== 1'b0) begin errors++; $display("FAIL idle_hold got=%0b/%0b exp=1/0", locked, err_pulse); end
   endtask

   task automatic test_wrap_up();
      logic [3:0] vals [4];
      do_reset();
      send(4'd6, 1'b1); send(4'd7, 1'b1); send(4'd8, 1'b1); send(4'd9, 1'b1);
      vals = '{4'd10, 4'd11, 4'd0, 4'd1};
      for (int i = 0; i < 4; i++) begin
         send(vals[i], 1'b1);
         checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pulse idx=%0d got=%0b exp=0", i, err_pulse); end
      end
      checks++; if (last_good !== 4'd1) begin errors++; $display("FAIL wrap_lastgood got=%0d exp=1", last_good); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got=%0b exp=1", locked); end
   endtask

   task automatic test_single_error();
      do_reset();
      send(4'd2, 1'b1); send(4'd3, 1'b1); send(4'd4, 1'b1); send(4'd5, 1'b1);
      send(4'd7, 1'b1);
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got=%0b exp=1", err_pulse); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", err_count); end
      send(4'd8, 1'b1);
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL resync_pulse got=%0b exp=0", err_pulse); end
      checks++; if (last_good !== 4'd8) begin errors++; $display("FAIL resync_lastgood got=%0d exp=8", last_good); end
      // miss was cleared by the match, so one more error must not alarm
      send(4'd10, 1'b1);
      checks++; if (alarm !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL miss_reset alarm=%0b locked=%0b exp=0/1", alarm, locked); end
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL single_count2 got=%0d exp=2", err_count); end
   endtask

   task automatic test_alarm();
      do_reset();
      send(4'd1, 1'b1); send(4'd2, 1'b1); send(4'd3, 1'b1); send(4'd4, 1'b1);
      send(4'd9, 1'b1);
      checks++; if (err_pulse !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL alarm_first pulse=%0b locked=%0b exp=1/1", err_pulse, locked); end
      send(4'd2, 1'b1);
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL alarm_second_pulse got=%0b exp=1", err_pulse); end
      checks++; if (alarm !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL alarm_raise alarm=%0b locked=%0b exp=1/0", alarm, locked); end
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL alarm_count got=%0d exp=2", err_count); end
      send(4'd3, 1'b1);
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL alarm_ignore got=%0b exp=0", err_pulse); end
      send(4'd15, 1'b1);
      checks++; if (err_pulse !== 1'b0 || err_count !== 8'd2) begin errors++; $display("FAIL alarm_illegal pulse=%0b count=%0d exp=0/2", err_pulse, err_count); end
   endtask

   task automatic test_illegal();
      do_reset();
      send(4'd13, 1'b1);
      checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL illegal_acq pulse=%0b count=%0d exp=1/1", err_pulse, err_count); end
      send(4'd5, 1'b1); send(4'd6, 1'b1); send(4'd7, 1'b1);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL illegal_reload_early got=%0b exp=0", locked); end
      send(4'd8, 1'b1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL illegal_reload_lock got=%0b exp=1", locked); end
      send(4'd14, 1'b1);
      checks++; if (err_pulse !== 1'b1 || locked !== 1'b1 || err_count !== 8'd2) begin errors++; $display("FAIL illegal_locked pulse=%0b locked=%0b count=%0d exp=1/1/2", err_pulse, locked, err_count); end
      send(4'd14, 1'b1);
      checks++; if (alarm !== 1'b1 || err_count !== 8'd3) begin errors++; $display("FAIL illegal_alarm alarm=%0b count=%0d exp=1/3", alarm, err_count); end
   endtask

   task automatic test_clear();
      // entered with alarm=1 from test_illegal
      @(negedge Clk);
      clear_alarm = 1'b1;
      in_valid = 1'b1;
      count_in = 4'd3;
      UpOrDown = 1'b0;
      @(posedge Clk);
      #1;
      clear_alarm = 1'b0;
      in_valid = 1'b0;
      checks++; if (alarm !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL clear_flags alarm=%0b locked=%0b exp=0/0", alarm, locked); end
      checks++; if (err_count !== 8'd0 || err_pulse !== 1'b0) begin errors++; $display("FAIL clear_count count=%0d pulse=%0b exp=0/0", err_count, err_pulse); end
      send(4'd2, 1'b0); send(4'd1, 1'b0); send(4'd0, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clear_dropped got=%0b exp=0", locked); end
      send(4'd11, 1'b0);
      checks++; if (locked !== 1'b1 || last_good !== 4'd11) begin errors++; $display("FAIL down_lock locked=%0b last=%0d exp=1/11", locked, last_good); end
   endtask

   task automatic test_reset_mid();
      // entered locked from test_clear
      @(negedge Clk);
      #2;
      reset = 1'b1;
      #1;
      checks++; if (locked !== 1'b0 || last_good !== 4'd0) begin errors++; $display("FAIL async_reset locked=%0b last=%0d exp=0/0", locked, last_good); end
      @(negedge Clk);
      reset = 1'b0;
      @(posedge Clk);
      #1;
      checks++; if (err_pulse !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_release pulse=%0b count=%0d exp=0/0", err_pulse, err_count); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 256; i++) send(4'd15, 1'b1);
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", err_count); end
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse got=%0b exp=1", err_pulse); end
   endtask

   initial begin
      test_reset();
      test_lock_up();
      test_wrap_up();
      test_single_error();
      test_alarm();
      test_illegal();
      test_clear();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
